multicycle_control: RTL and testbench

- Main control FSM for the multi-cycle MIPS-subset datapath.
- Sequences fetch / decode / execute / memory / writeback for each instruction.
- Drives the datapath muxes, register file and memory enables.
- Produces the 2-bit ALU_OP consumed by the existing ALU control decoder.
- Stalls on a single-ready memory handshake.

---
 rtl/ctrl_pkg.sv | 59 +++++
 rtl/ctrl_output_decoder.sv | 76 +++++++
 rtl/multicycle_control.sv | 109 ++++++++++
 tb/tb_multicycle_control.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control FSM: opcodes, state codes,
// mux select codes and the packed control word driven by ctrl_output_decoder.
package ctrl_pkg;

  localparam int unsigned StateW = 4;
  localparam int unsigned OpW    = 6;

  localparam logic [OpW-1:0] OpRtype = 6'b000000;
  localparam logic [OpW-1:0] OpLw    = 6'b100011;
  localparam logic [OpW-1:0] OpSw    = 6'b101011;
  localparam logic [OpW-1:0] OpBeq   = 6'b000100;
  localparam logic [OpW-1:0] OpAddi  = 6'b001000;
  localparam logic [OpW-1:0] OpJ     = 6'b000010;

  localparam logic [StateW-1:0] StFetch  = 4'd0;
  localparam logic [StateW-1:0] StDecode = 4'd1;
  localparam logic [StateW-1:0] StMemAdr = 4'd2;
  localparam logic [StateW-1:0] StMemRd  = 4'd3;
  localparam logic [StateW-1:0] StMemWb  = 4'd4;
  localparam logic [StateW-1:0] StMemWr  = 4'd5;
  localparam logic [StateW-1:0] StExec   = 4'd6;
  localparam logic [StateW-1:0] StRWb    = 4'd7;
  localparam logic [StateW-1:0] StBranch = 4'd8;
  localparam logic [StateW-1:0] StJump   = 4'd9;
  localparam logic [StateW-1:0] StAddiEx = 4'd10;
  localparam logic [StateW-1:0] StAddiWb = 4'd11;
  localparam logic [StateW-1:0] StTrap   = 4'd15;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SrcBReg   = 2'b00;
  localparam logic [1:0] SrcBFour  = 2'b01;
  localparam logic [1:0] SrcBImm   = 2'b10;
  localparam logic [1:0] SrcBImmSh = 2'b11;

  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       retire;
  } ctrl_word_t;

endpackage

// File: rtl/ctrl_output_decoder.sv
// Combinational map from FSM state (plus MEM_READY for handshake-qualified strobes)
// to the datapath control word. Unlisted states, including TRAP, decode to all zeros.
module ctrl_output_decoder
  import ctrl_pkg::*;
(
  input  logic [StateW-1:0] state_i,
  input  logic              mem_ready_i,
  output ctrl_word_t        ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      StFetch: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SrcBFour;
        ctrl_o.alu_op    = ALUOP_ADD;
        ctrl_o.pc_src    = PcSrcAlu;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      StDecode: begin
        ctrl_o.alu_src_b = SrcBImmSh;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      StMemAdr, StAddiEx: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SrcBImm;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      StMemRd: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.i_or_d   = 1'b1;
      end
      StMemWb: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.retire     = 1'b1;
      end
      StMemWr: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.i_or_d    = 1'b1;
        ctrl_o.retire    = mem_ready_i;
      end
      StExec: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SrcBReg;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      StRWb: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
        ctrl_o.retire    = 1'b1;
      end
      StBranch: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = SrcBReg;
        ctrl_o.alu_op        = ALUOP_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_src        = PcSrcAluOut;
        ctrl_o.retire        = 1'b1;
      end
      StJump: begin
        ctrl_o.pc_write = 1'b1;
        ctrl_o.pc_src   = PcSrcJump;
        ctrl_o.retire   = 1'b1;
      end
      StAddiWb: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.retire    = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS-subset datapath: state register and next-state
// logic. Define MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN to trap unknown opcodes (adds ILLEGAL).
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int unsigned OPW = 6,
  parameter int unsigned STW = 4
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic [OPW-1:0] OPCODE,
  input  logic           ZERO,
  input  logic           MEM_READY,
  output logic           PC_WRITE,
  output logic           PC_WRITE_COND,
  output logic           PC_EN,
  output logic           I_OR_D,
  output logic           MEM_READ,
  output logic           MEM_WRITE,
  output logic           IR_WRITE,
  output logic           REG_DST,
  output logic           MEM_TO_REG,
  output logic           REG_WRITE,
  output logic           ALU_SRC_A,
  output logic [1:0]     ALU_SRC_B,
  output logic [1:0]     ALU_OP,
  output logic [1:0]     PC_SRC,
  output logic           RETIRE,
  output logic [STW-1:0] STATE
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
  ,
  output logic           ILLEGAL
`endif
);

  logic [StateW-1:0] state_q, state_d;
  logic [OpW-1:0]    opcode;
  ctrl_word_t        ctrl;

  assign opcode = OpW'(OPCODE);

  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch:  state_d = MEM_READY ? StDecode : StFetch;
      StDecode: begin
        case (opcode)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtype:    state_d = StExec;
          OpBeq:      state_d = StBranch;
          OpJ:        state_d = StJump;
          OpAddi:     state_d = StAddiEx;
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
          default:    state_d = StTrap;
`else
          // Unknown opcode retires nothing and simply refetches.
          default:    state_d = StFetch;
`endif
        endcase
      end
      StMemAdr: state_d = (opcode == OpSw) ? StMemWr : StMemRd;
      StMemRd:  state_d = MEM_READY ? StMemWb : StMemRd;
      StMemWr:  state_d = MEM_READY ? StFetch : StMemWr;
      StExec:   state_d = StRWb;
      StAddiEx: state_d = StAddiWb;
      StMemWb, StRWb, StBranch, StJump, StAddiWb: state_d = StFetch;
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
      StTrap:   state_d = StTrap;
`endif
      default:  state_d = StFetch;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  ctrl_output_decoder u_ctrl_output_decoder (
    .state_i     (state_q),
    .mem_ready_i (MEM_READY),
    .ctrl_o      (ctrl)
  );

  assign PC_WRITE      = ctrl.pc_write;
  assign PC_WRITE_COND = ctrl.pc_write_cond;
  assign PC_EN         = ctrl.pc_write | (ctrl.pc_write_cond & ZERO);
  assign I_OR_D        = ctrl.i_or_d;
  assign MEM_READ      = ctrl.mem_read;
  assign MEM_WRITE     = ctrl.mem_write;
  assign IR_WRITE      = ctrl.ir_write;
  assign REG_DST       = ctrl.reg_dst;
  assign MEM_TO_REG    = ctrl.mem_to_reg;
  assign REG_WRITE     = ctrl.reg_write;
  assign ALU_SRC_A     = ctrl.alu_src_a;
  assign ALU_SRC_B     = ctrl.alu_src_b;
  assign ALU_OP        = ctrl.alu_op;
  assign PC_SRC        = ctrl.pc_src;
  assign RETIRE        = ctrl.retire;
  assign STATE         = STW'(state_q);

`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
  assign ILLEGAL = (state_q == StTrap);
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed, table-driven bench for multicycle_control: one vector per clock cycle, plus
// hand-written latency and illegal-opcode sequences.
module tb_multicycle_control;

  // Expected control word, packed as
  // {pcw,pcwc,pcen}_{iord,mrd,mwr,irw}_{rdst,m2r,rw}_{srca}_{srcb}_{aluop}_{pcsrc}_{ret}
  localparam logic [17:0] WFetchR  = 18'b101_0101_000_0_01_00_00_0;
  localparam logic [17:0] WFetchS  = 18'b000_0100_000_0_01_00_00_0;
  localparam logic [17:0] WDecode  = 18'b000_0000_000_0_11_00_00_0;
  localparam logic [17:0] WMemAdr  = 18'b000_0000_000_1_10_00_00_0;
  localparam logic [17:0] WMemRd   = 18'b000_1100_000_0_00_00_00_0;
  localparam logic [17:0] WMemWb   = 18'b000_0000_011_0_00_00_00_1;
  localparam logic [17:0] WMemWrS  = 18'b000_1010_000_0_00_00_00_0;
  localparam logic [17:0] WMemWrR  = 18'b000_1010_000_0_00_00_00_1;
  localparam logic [17:0] WExec    = 18'b000_0000_000_1_00_10_00_0;
  localparam logic [17:0] WRWb     = 18'b000_0000_101_0_00_00_00_1;
  localparam logic [17:0] WBrZ1    = 18'b011_0000_000_1_00_01_01_1;
  localparam logic [17:0] WBrZ0    = 18'b010_0000_000_1_00_01_01_1;
  localparam logic [17:0] WJump    = 18'b101_0000_000_0_00_00_10_1;
  localparam logic [17:0] WAddiEx  = 18'b000_0000_000_1_10_00_00_0;
  localparam logic [17:0] WAddiWb  = 18'b000_0000_001_0_00_00_00_1;
  localparam logic [17:0] WNone    = 18'b000_0000_000_0_00_00_00_0;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
  localparam logic [5:0] RT = 6'b000000, ADDI = 6'b001000, JMP = 6'b000010, BAD = 6'b111111;

  typedef struct {
    logic        chk;
    logic        rst_n;
    logic [5:0]  op;
    logic        rdy;
    logic        zero;
    logic [3:0]  exp_state;
    logic [17:0] exp_word;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, pc_en, i_or_d, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a, retire;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state;
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
  logic       illegal;
`endif

  int n_vec = 0;
  int n_err = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  multicycle_control #(.OPW(6), .STW(4)) dut (
    .CLK           (clk),
    .RST_N         (rst_n),
    .OPCODE        (opcode),
    .ZERO          (zero),
    .MEM_READY     (mem_ready),
    .PC_WRITE      (pc_write),
    .PC_WRITE_COND (pc_write_cond),
    .PC_EN         (pc_en),
    .I_OR_D        (i_or_d),
    .MEM_READ      (mem_read),
    .MEM_WRITE     (mem_write),
    .IR_WRITE      (ir_write),
    .REG_DST       (reg_dst),
    .MEM_TO_REG    (mem_to_reg),
    .REG_WRITE     (reg_write),
    .ALU_SRC_A     (alu_src_a),
    .ALU_SRC_B     (alu_src_b),
    .ALU_OP        (alu_op),
    .PC_SRC        (pc_src),
    .RETIRE        (retire),
    .STATE         (state)
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
    ,
    .ILLEGAL       (illegal)
`endif
  );

  function automatic logic [17:0] act_word();
    return {pc_write, pc_write_cond, pc_en, i_or_d, mem_read, mem_write, ir_write,
            reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_src, retire};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic c, input logic r, input logic [5:0] o, input logic rd,
                     input logic z, input logic [3:0] s, input logic [17:0] w);
    vec_t v;
    v.chk = c; v.rst_n = r; v.op = o; v.rdy = rd; v.zero = z;
    v.exp_state = s; v.exp_word = w;
    tbl.push_back(v);
  endtask

  // Cycles from FETCH until RETIRE with MEM_READY high; bounded so a hang reads as a miscompare.
  task automatic run_latency(input logic [5:0] op, input int exp, input string nm);
    int cyc = 0;
    bit done = 0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      opcode = op; mem_ready = 1'b1; zero = 1'b1;
      #1;
      cyc++;
      if (retire) done = 1;
    end
    check(nm, cyc, exp);
  endtask

  initial begin
    // chk rst op rdy z state word
    add(0, 0, LW,  1, 0, 4'd0,  WNone);
    add(0, 0, LW,  1, 0, 4'd0,  WNone);
    add(1, 1, LW,  1, 0, 4'd0,  WFetchR);   // LW, 5 cycles
    add(1, 1, LW,  1, 0, 4'd1,  WDecode);
    add(1, 1, LW,  1, 0, 4'd2,  WMemAdr);
    add(1, 1, LW,  1, 0, 4'd3,  WMemRd);
    add(1, 1, LW,  1, 0, 4'd4,  WMemWb);
    add(1, 1, SW,  1, 0, 4'd0,  WFetchR);   // SW with 3 wait cycles
    add(1, 1, SW,  1, 0, 4'd1,  WDecode);
    add(1, 1, SW,  1, 0, 4'd2,  WMemAdr);
    add(1, 1, SW,  0, 0, 4'd5,  WMemWrS);
    add(1, 1, SW,  0, 0, 4'd5,  WMemWrS);
    add(1, 1, SW,  0, 0, 4'd5,  WMemWrS);
    add(1, 1, SW,  1, 0, 4'd5,  WMemWrR);
    add(1, 1, BEQ, 1, 1, 4'd0,  WFetchR);   // BEQ taken
    add(1, 1, BEQ, 1, 1, 4'd1,  WDecode);
    add(1, 1, BEQ, 1, 1, 4'd8,  WBrZ1);
    add(1, 1, BEQ, 1, 0, 4'd0,  WFetchR);   // BEQ not taken
    add(1, 1, BEQ, 1, 0, 4'd1,  WDecode);
    add(1, 1, BEQ, 1, 0, 4'd8,  WBrZ0);
    add(1, 1, RT,  1, 0, 4'd0,  WFetchR);   // R-type then ADDI
    add(1, 1, RT,  1, 0, 4'd1,  WDecode);
    add(1, 1, RT,  1, 0, 4'd6,  WExec);
    add(1, 1, RT,  1, 0, 4'd7,  WRWb);
    add(1, 1, ADDI, 1, 0, 4'd0,  WFetchR);
    add(1, 1, ADDI, 1, 0, 4'd1,  WDecode);
    add(1, 1, ADDI, 1, 0, 4'd10, WAddiEx);
    add(1, 1, ADDI, 1, 0, 4'd11, WAddiWb);
    add(1, 1, JMP, 1, 0, 4'd0,  WFetchR);   // J
    add(1, 1, JMP, 1, 0, 4'd1,  WDecode);
    add(1, 1, JMP, 1, 0, 4'd9,  WJump);
    add(1, 1, LW,  0, 0, 4'd0,  WFetchS);   // fetch stall, then read stall
    add(1, 1, LW,  1, 0, 4'd0,  WFetchR);
    add(1, 1, LW,  1, 0, 4'd1,  WDecode);
    add(1, 1, LW,  1, 0, 4'd2,  WMemAdr);
    add(1, 1, LW,  0, 0, 4'd3,  WMemRd);
    add(1, 1, LW,  1, 0, 4'd3,  WMemRd);
    add(1, 1, LW,  1, 0, 4'd4,  WMemWb);
    add(1, 1, LW,  1, 0, 4'd0,  WFetchR);   // reset mid MEM_RD
    add(1, 1, LW,  1, 0, 4'd1,  WDecode);
    add(1, 1, LW,  1, 0, 4'd2,  WMemAdr);
    add(1, 1, LW,  0, 0, 4'd3,  WMemRd);
    add(1, 0, LW,  0, 0, 4'd3,  WMemRd);
    add(1, 0, LW,  0, 0, 4'd0,  WFetchS);
    add(1, 1, SW,  0, 0, 4'd0,  WFetchS);
    add(1, 1, BAD, 1, 0, 4'd0,  WFetchR);   // unknown opcode
    add(1, 1, BAD, 1, 0, 4'd1,  WDecode);
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
    add(1, 1, BAD, 1, 0, 4'd15, WNone);
    add(1, 1, LW,  1, 0, 4'd15, WNone);
`else
    add(1, 1, BAD, 1, 0, 4'd0,  WFetchR);
    add(1, 1, BAD, 1, 0, 4'd1,  WDecode);
`endif

    foreach (tbl[i]) begin
      @(negedge clk);
      rst_n = tbl[i].rst_n; opcode = tbl[i].op;
      mem_ready = tbl[i].rdy; zero = tbl[i].zero;
      #1;
      if (tbl[i].chk) begin
        check($sformatf("vec%0d state", i), 32'(state), 32'(tbl[i].exp_state));
        check($sformatf("vec%0d ctrl", i), 32'(act_word()), 32'(tbl[i].exp_word));
      end
    end

    @(negedge clk);
    rst_n = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post-reset state", 32'(state), 32'd0);

    run_latency(LW,   5, "lat LW");
    run_latency(SW,   4, "lat SW");
    run_latency(RT,   4, "lat RTYPE");
    run_latency(ADDI, 4, "lat ADDI");
    run_latency(BEQ,  3, "lat BEQ");
    run_latency(JMP,  3, "lat J");

`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
    begin
      int rets = 0;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        opcode = BAD; mem_ready = 1'b1;
        #1;
        if (retire) rets++;
      end
      check("trap state", 32'(state), 32'd15);
      check("trap ILLEGAL", 32'(illegal), 32'd1);
      check("trap no retire", 32'(rets), 32'd0);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("trap cleared state", 32'(state), 32'd0);
      check("trap cleared ILLEGAL", 32'(illegal), 32'd0);
    end
`else
    begin
      int rets = 0;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        opcode = BAD; mem_ready = 1'b1;
        #1;
        if (retire) rets++;
      end
      check("nop no retire", 32'(rets), 32'd0);
      check("nop back to fetch", 32'(state), 32'd0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
